// File: rtl/rf_op_sequencer_if.sv
// Op request handshake plus register-file port bundle for rf_op_sequencer.
// master = requester/register-file side, slave = sequencer side.
interface rf_op_sequencer_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs;
    logic [AW-1:0] in_rt;
    logic [DW-1:0] in_imm;

    logic          WEN;
    logic [AW-1:0] RW;
    logic [DW-1:0] busW;
    logic [AW-1:0] RX;
    logic [AW-1:0] RY;
    logic [DW-1:0] busX;
    logic [DW-1:0] busY;

    logic          done;
    logic [DW-1:0] result;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, busX, busY,
        input  in_ready, WEN, RW, busW, RX, RY, done, result
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, busX, busY,
        output in_ready, WEN, RW, busW, RX, RY, done, result
    );
endinterface

// File: rtl/rf_op_sequencer.sv
// Three-state register-file op sequencer (ADD, SUB/XOR, AND, LDI).
// Macro RF_SEQ_SUB_EN: opcode 01 executes SUB when defined, XOR otherwise.
//
// state | meaning
// IDLE  | in_ready high, waiting for an op transfer
// READ  | RX/RY drive rs/rt, operands captured on the exit edge
// WRITE | write port driven (WEN unless rd=0), done pulse
module rf_op_sequencer #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input logic           Clk,
    input logic           Rst_n,
    rf_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    state_t        state;
    logic [1:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs_q;
    logic [AW-1:0] rt_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] op_x;
    logic [DW-1:0] op_y;
    logic [DW-1:0] alu;
    logic          in_write;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            rd_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            imm_q <= '0;
            op_x  <= '0;
            op_y  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.in_op;
                        rd_q  <= bus.in_rd;
                        rs_q  <= bus.in_rs;
                        rt_q  <= bus.in_rt;
                        imm_q <= bus.in_imm;
                        state <= (bus.in_op == OP_LDI) ? WRITE : READ;
                    end
                end
                READ: begin
                    op_x  <= bus.busX;
                    op_y  <= bus.busY;
                    state <= WRITE;
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Carry and borrow fall off the top naturally at DW bits.
    always_comb begin
        alu = '0;
        case (op_q)
            OP_ADD: alu = op_x + op_y;
`ifdef RF_SEQ_SUB_EN
            OP_SUB: alu = op_x - op_y;
`else
            OP_SUB: alu = op_x ^ op_y;
`endif
            OP_AND: alu = op_x & op_y;
            OP_LDI: alu = imm_q;
            default: alu = '0;
        endcase
    end

    // Outputs decode only from registered state, so reset clears them at once.
    assign in_write     = (state == WRITE);
    assign bus.in_ready = (state == IDLE);
    assign bus.RX       = (state == READ) ? rs_q : '0;
    assign bus.RY       = (state == READ) ? rt_q : '0;
    assign bus.WEN      = in_write && (rd_q != '0);
    assign bus.RW       = in_write ? rd_q : '0;
    assign bus.busW     = in_write ? alu : '0;
    assign bus.done     = in_write;
    assign bus.result   = in_write ? alu : '0;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed self-checking bench for rf_op_sequencer with a small register file model.
module tb_rf_op_sequencer;
    logic Clk;
    logic Rst_n;
    int   checks;
    int   passed;
    logic [7:0] rf [8];

    rf_op_sequencer_if #(.AW(3), .DW(8)) bus ();

    rf_op_sequencer #(.AW(3), .DW(8)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign bus.busX = rf[bus.RX];
    assign bus.busY = rf[bus.RY];

    always @(posedge Clk) begin
        if (bus.WEN) rf[bus.RW] <= bus.busW;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one op, takes the accept edge, then scrambles the inputs.
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm);
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        check("ready_before_accept", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_op    = 2'(($urandom_range(0, 3)));
        bus.in_rd    = 3'($urandom_range(0, 7));
        bus.in_rs    = 3'($urandom_range(0, 7));
        bus.in_rt    = 3'($urandom_range(0, 7));
        bus.in_imm   = 8'($urandom_range(0, 255));
    endtask

    int acc_n;
    int acc_edge [4];
    logic [7:0] op01_exp;

    initial begin
        checks = 0;
        passed = 0;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_op    = 2'b00;
        bus.in_rd    = 3'd0;
        bus.in_rs    = 3'd0;
        bus.in_rt    = 3'd0;
        bus.in_imm   = 8'h00;
        Rst_n = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_wen", bus.WEN, 0);
        check("rst_rw", bus.RW, 0);
        check("rst_busw", bus.busW, 0);
        check("rst_rx", bus.RX, 0);
        check("rst_ry", bus.RY, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        check("idle_ready", bus.in_ready, 1);

        // LDI R1,5 and LDI R2,3
        issue(2'b11, 3'd1, 3'd0, 3'd0, 8'd5);
        check("ldi1_wen", bus.WEN, 1);
        check("ldi1_rw", bus.RW, 1);
        check("ldi1_busw", bus.busW, 5);
        check("ldi1_done", bus.done, 1);
        check("ldi1_ready_low", bus.in_ready, 0);
        check("ldi1_rx_zero", bus.RX, 0);
        tick();
        check("ldi1_wen_drop", bus.WEN, 0);
        check("ldi1_done_drop", bus.done, 0);
        check("ldi1_ready_back", bus.in_ready, 1);
        check("ldi1_busw_idle", bus.busW, 0);
        issue(2'b11, 3'd2, 3'd0, 3'd0, 8'd3);
        check("ldi2_wen", bus.WEN, 1);
        check("ldi2_rw", bus.RW, 2);
        check("ldi2_busw", bus.busW, 3);
        check("ldi2_done", bus.done, 1);
        tick();
        check("ldi2_ready_back", bus.in_ready, 1);

        // ADD R3,R1,R2
        issue(2'b00, 3'd3, 3'd1, 3'd2, 8'h00);
        check("add_rx", bus.RX, 1);
        check("add_ry", bus.RY, 2);
        check("add_read_wen", bus.WEN, 0);
        check("add_read_done", bus.done, 0);
        check("add_read_ready", bus.in_ready, 0);
        tick();
        check("add_wen", bus.WEN, 1);
        check("add_rw", bus.RW, 3);
        check("add_busw", bus.busW, 8);
        check("add_result", bus.result, 8);
        check("add_write_rx", bus.RX, 0);
        tick();
        check("add_ready_back", bus.in_ready, 1);
        check("add_r3", rf[3], 8);

        // op 01 R4,R2,R1: 3-5 = FE, 3^5 = 06
`ifdef RF_SEQ_SUB_EN
        op01_exp = 8'hFE;
`else
        op01_exp = 8'h06;
`endif
        issue(2'b01, 3'd4, 3'd2, 3'd1, 8'h00);
        tick();
        check("op01_busw", bus.busW, 32'(op01_exp));
        tick();
        check("op01_r4", rf[4], 32'(op01_exp));

        // op 01 with rs=rt gives 0 for both SUB and XOR
        issue(2'b01, 3'd4, 3'd3, 3'd3, 8'h00);
        tick();
        check("same_reg_busw", bus.busW, 0);
        tick();

        // AND R6,R1,R2 = 5&3 = 1
        issue(2'b10, 3'd6, 3'd1, 3'd2, 8'h00);
        tick();
        check("and_busw", bus.busW, 1);
        tick();

        // ADD R0,R1,R2: no write, done still pulses
        issue(2'b00, 3'd0, 3'd1, 3'd2, 8'h00);
        tick();
        check("r0_wen", bus.WEN, 0);
        check("r0_done", bus.done, 1);
        check("r0_result", bus.result, 8);
        tick();
        check("r0_still_zero", rf[0], 0);

        // 0xFF + 0x02 wraps to 0x01
        issue(2'b11, 3'd5, 3'd0, 3'd0, 8'hFF);
        tick();
        issue(2'b11, 3'd6, 3'd0, 3'd0, 8'h02);
        tick();
        issue(2'b00, 3'd7, 3'd5, 3'd6, 8'h00);
        tick();
        check("wrap_busw", bus.busW, 1);
        tick();

        // in_valid held high: accepts on edges 0, 3, 6
        acc_n = 0;
        bus.in_op    = 2'b10;
        bus.in_rd    = 3'd7;
        bus.in_rs    = 3'd1;
        bus.in_rt    = 3'd2;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (bus.in_ready) begin
                if (acc_n < 4) acc_edge[acc_n] = c;
                acc_n++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        check("stream_accepts", 32'(acc_n), 3);
        check("stream_edge0", 32'(acc_edge[0]), 0);
        check("stream_edge1", 32'(acc_edge[1]), 3);
        check("stream_edge2", 32'(acc_edge[2]), 6);
        check("stream_ready_back", bus.in_ready, 1);

        // Reset during READ of ADD R5,R1,R2 aborts the op
        issue(2'b00, 3'd5, 3'd1, 3'd2, 8'h00);
        check("abort_rx_read", bus.RX, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("abort_wen", bus.WEN, 0);
        check("abort_done", bus.done, 0);
        check("abort_rx", bus.RX, 0);
        check("abort_ready", bus.in_ready, 1);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        check("abort_ready_after", bus.in_ready, 1);
        check("abort_no_done", bus.done, 0);
        tick();
        check("abort_r5_kept", rf[5], 8'hFF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
